// File: rtl/prio_enc_seq.sv
// Registered N-input priority encoder with sticky request latching and a valid/ready output.
// Define PRIO_ENC_RR_EN for round-robin priority; default is fixed priority (highest index wins).
module prio_enc_seq #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             none_on,
    output logic [IDX_W:0]   pend_cnt
);

    logic [N-1:0]     pend_q, pend_d, clr;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d, sel;
    logic             none_on_q;
    logic [IDX_W:0]   pend_cnt_q, cnt_d;
    logic             slot_free, any_pend, load;

    function automatic logic [IDX_W-1:0] hi_idx(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

`ifdef PRIO_ENC_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     low_mask, low_pend;

    // Search ptr..0 first, then wrap to N-1..ptr+1: split pend at ptr and prefer the lower slice.
    always_comb begin
        low_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            low_mask[i] = (IDX_W'(i) <= ptr_q);
        end
        low_pend = pend_q & low_mask;
        sel      = (|low_pend) ? hi_idx(low_pend) : hi_idx(pend_q);
        ptr_d    = ptr_q;
        if (load) ptr_d = (sel == '0) ? IDX_W'(N - 1) : sel - IDX_W'(1);
    end
`else
    always_comb sel = hi_idx(pend_q);
`endif

    always_comb begin
        slot_free   = ~out_valid_q | out_ready;
        any_pend    = |pend_q;
        load        = slot_free & any_pend;
        clr         = load ? (N'(1) << sel) : '0;
        pend_d      = (pend_q & ~clr) | req;
        out_valid_d = slot_free ? any_pend : out_valid_q;
        out_idx_d   = load ? sel : out_idx_q;
        cnt_d       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_d = cnt_d + (IDX_W + 1)'(pend_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            none_on_q   <= 1'b1;
            pend_cnt_q  <= '0;
`ifdef PRIO_ENC_RR_EN
            ptr_q       <= IDX_W'(N - 1);
`endif
        end else begin
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            none_on_q   <= ~(|pend_d) & ~out_valid_d;
            pend_cnt_q  <= cnt_d;
`ifdef PRIO_ENC_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign none_on   = none_on_q;
    assign pend_cnt  = pend_cnt_q;

endmodule

// File: tb/tb_prio_enc_seq.sv
// Self-checking bench for prio_enc_seq: directed scenarios plus random traffic against a
// behavioural model (follows PRIO_ENC_RR_EN the same way the design does).
module tb_prio_enc_seq;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             none_on;
    logic [IDX_W:0]   pend_cnt;

    int checks = 0;
    int errors = 0;

    bit m_pend[N];
    bit m_valid;
    int m_idx;
    int m_ptr;

    prio_enc_seq #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .none_on   (none_on),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < N; k++) c += m_pend[k];
        return c;
    endfunction

    // Walk the priority order from the start point downwards with wrap-around.
    function automatic int m_winner();
        int start;
`ifdef PRIO_ENC_RR_EN
        start = m_ptr;
`else
        start = N - 1;
`endif
        for (int k = 0; k < N; k++) begin
            int i = (start - k + N) % N;
            if (m_pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = N - 1;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic rdy);
        int s;
        if (!m_valid || rdy) begin
            s = m_winner();
            if (s >= 0) begin
                m_valid   = 1'b1;
                m_idx     = s;
                m_pend[s] = 1'b0;
                m_ptr     = (s == 0) ? N - 1 : s - 1;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int k = 0; k < N; k++) if (r[k]) m_pend[k] = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/valid"}, int'(out_valid), int'(m_valid));
        check({tag, "/idx"},   int'(out_idx),   m_idx);
        check({tag, "/none"},  int'(none_on),   int'(m_count() == 0 && !m_valid));
        check({tag, "/cnt"},   int'(pend_cnt),  m_count());
    endtask

    task automatic step(input logic [N-1:0] r, input logic rdy, input string tag);
        req       = r;
        out_ready = rdy;
        @(posedge clk);
        model_edge(r, rdy);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        logic [N-1:0] r;
        logic         rdy;

        rst_n     = 1'b0;
        req       = '1;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        req   = '0;
        rst_n = 1'b1;
        step('0, 1'b0, "post_rst0");
        step('0, 1'b1, "post_rst1");

        // Burst of three requests drains highest-first.
        step(8'b1010_0100, 1'b1, "a4_pulse");
        check("a4_cnt0", int'(pend_cnt), 3);
        step('0, 1'b1, "a4_g0"); check("a4_idx7", int'(out_idx), 7);
        step('0, 1'b1, "a4_g1"); check("a4_idx5", int'(out_idx), 5);
        step('0, 1'b1, "a4_g2"); check("a4_idx2", int'(out_idx), 2);
        step('0, 1'b1, "a4_idle"); check("a4_none", int'(none_on), 1);

        // Backpressure: 5 held while 7 accumulates behind it.
        step(8'h20, 1'b1, "bp_pulse");
        step('0, 1'b0, "bp_load");
        step(8'h80, 1'b0, "bp_req7");
        for (int k = 0; k < 3; k++) step('0, 1'b0, "bp_hold");
        check("bp_idx5", int'(out_idx), 5);
        check("bp_cnt1", int'(pend_cnt), 1);
        step('0, 1'b1, "bp_acc"); check("bp_idx7", int'(out_idx), 7);
        step('0, 1'b1, "bp_drain");

        // Request for idx 3 arriving as idx 3 is accepted is kept.
        step(8'h08, 1'b1, "col_pulse");
        step('0, 1'b1, "col_load");
        step(8'h08, 1'b1, "col_hit"); check("col_cnt", int'(pend_cnt), 1);
        step('0, 1'b1, "col_regrant"); check("col_idx3", int'(out_idx), 3);
        step('0, 1'b1, "col_drain");

        // Starvation / fairness with two requests held.
        for (int k = 0; k < 8; k++) step(8'b0000_0011, 1'b1, "fair");
        for (int k = 0; k < 3; k++) step('0, 1'b1, "fair_drain");

        // Asynchronous reset while presenting with four pending.
        step(8'hF8, 1'b0, "mr_pulse");
        step('0, 1'b0, "mr_load");
        check("mr_cnt4", int'(pend_cnt), 4);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step('0, 1'b1, "mr_after");

        for (int k = 0; k < 400; k++) begin
            r   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            rdy = ($urandom_range(0, 3) != 0);
            step(r, rdy, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
